// File: rtl/bcd_pkg.sv
// Shared BCD constants and a nibble validity helper used by the decade
// counter and its per-digit cells.
package bcd_pkg;
  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_MIN     = 4'd0;

  function automatic logic bcd_nibble_ok(input logic [BCD_DIGIT_W-1:0] n);
    return n <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: holds a value 0..9, steps up or down on step_in and
// reports carry/borrow on step_out when it rolls past its terminal value.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_val,
  input  logic                   step_in,
  input  logic                   up,
  input  logic                   hold,
  output logic                   step_out,
  output logic [BCD_DIGIT_W-1:0] value
);
  logic [BCD_DIGIT_W-1:0] value_q, value_d;

  // hold freezes the value without disturbing the carry chain, so a
  // saturating counter can veto a step that would overflow every decade.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (step_in && !hold) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? BCD_MIN : value_q + 4'd1;
      end else begin
        value_d = (value_q == BCD_MIN) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= BCD_MIN;
    end else begin
      value_q <= value_d;
    end
  end

  assign step_out = step_in & (up ? (value_q == BCD_MAX) : (value_q == BCD_MIN));
  assign value    = value_q;
endmodule

// File: rtl/bcd_counter_n.sv
// Multi-decade up/down BCD counter with a clock prescaler, validated
// synchronous load and selectable wrap or saturate at the terminal value.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DIV    = 50_000_000,
  parameter int WRAP   = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count,
  output logic                          tick,
  output logic                          tc,
  output logic                          load_err
);
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          load_err_q;
  logic          load_ok;
  logic          load_apply;
  logic          all_max;
  logic          all_min;
  logic          sat_hold;

  always_comb begin
    load_ok = 1'b1;
    all_max = 1'b1;
    all_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_nibble_ok(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) load_ok = 1'b0;
      if (count[i*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_MAX) all_max = 1'b0;
      if (count[i*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_MIN) all_min = 1'b0;
    end
  end

  assign load_apply = load & load_ok;
  assign tick       = en & (pre_q == PRE_LAST) & ~load & ~reset;
  assign tc         = up ? all_max : all_min;

  // A rejected load still blocks the prescaler: it neither advances nor clears.
  always_comb begin
    pre_d = pre_q;
    if (load) begin
      if (load_ok) pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      load_err_q <= load & ~load_ok;
    end
  end

  assign load_err = load_err_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic step_in_w;
    logic step_out_w;

    if (g == 0) begin : g_first
      assign step_in_w = tick;
    end else begin : g_next
      assign step_in_w = g_digit[g-1].step_out_w;
    end

    bcd_digit u_digit (
      .clk      (CLOCK_50),
      .reset    (reset),
      .load     (load_apply),
      .load_val (load_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_in  (step_in_w),
      .up       (up),
      .hold     (sat_hold),
      .step_out (step_out_w),
      .value    (count[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Carry out of the top decade means every digit sits at its terminal value.
  assign sat_hold = (WRAP == 0) & g_digit[DIGITS-1].step_out_w;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a wrapping and a saturating DIV=4 instance plus a
// DIV=1 instance share one stimulus stream; a monitor checks queued expectations.
module tb_bcd_counter_n;
  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [7:0] lv;

  logic [7:0] cnt_w, cnt_s, cnt_f;
  logic       tk_w, tk_s, tk_f;
  logic       tc_w, tc_s, tc_f;
  logic       le_w, le_s, le_f;

  typedef struct packed {
    logic [31:0] cyc;
    logic        main_chk;
    logic [7:0]  cw;
    logic [7:0]  cs;
    logic        tk;
    logic        tcw;
    logic        tcs;
    logic        le;
    logic        fast_chk;
    logic [7:0]  cf;
    logic        tkf;
    logic        tcf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] cyc_cnt;
  int          n_checks;
  int          n_fail;

  bcd_counter_n #(.DIGITS(2), .DIV(4), .WRAP(1)) u_wrap (
    .CLOCK_50(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv),
    .count(cnt_w), .tick(tk_w), .tc(tc_w), .load_err(le_w)
  );

  bcd_counter_n #(.DIGITS(2), .DIV(4), .WRAP(0)) u_sat (
    .CLOCK_50(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv),
    .count(cnt_s), .tick(tk_s), .tc(tc_s), .load_err(le_s)
  );

  bcd_counter_n #(.DIGITS(2), .DIV(1), .WRAP(1)) u_fast (
    .CLOCK_50(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv),
    .count(cnt_f), .tick(tk_f), .tc(tc_f), .load_err(le_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  function automatic logic [7:0] bcd2(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv,
                       input logic [31:0] c);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
    end
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [7:0] v);
    rst = r;
    en  = e;
    up  = u;
    ld  = l;
    lv  = v;
  endtask

  task automatic step_free(input logic r, input logic e, input logic u, input logic l,
                           input logic [7:0] v);
    drive(r, e, u, l, v);
    @(posedge clk);
    #1;
  endtask

  task automatic step_main(input logic r, input logic e, input logic u, input logic l,
                           input logic [7:0] v, input logic [7:0] cw, input logic [7:0] cs,
                           input logic tk, input logic tcw, input logic tcs, input logic le);
    exp_t x;
    drive(r, e, u, l, v);
    x = '0;
    x.cyc = cyc_cnt;
    x.main_chk = 1'b1;
    x.cw = cw;
    x.cs = cs;
    x.tk = tk;
    x.tcw = tcw;
    x.tcs = tcs;
    x.le = le;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic step_fast(input logic r, input logic e, input logic u, input logic l,
                           input logic [7:0] v, input logic [7:0] cf, input logic tkf,
                           input logic tcf);
    exp_t x;
    drive(r, e, u, l, v);
    x = '0;
    x.cyc = cyc_cnt;
    x.fast_chk = 1'b1;
    x.cf = cf;
    x.tkf = tkf;
    x.tcf = tcf;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: samples on the falling edge, away from state updates
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc != cyc_cnt) begin
        check("stale_expectation", 8'(cyc_cnt), 8'(mon_e.cyc), cyc_cnt);
      end else begin
        if (mon_e.main_chk) begin
          check("count_wrap", cnt_w, mon_e.cw, cyc_cnt);
          check("count_sat", cnt_s, mon_e.cs, cyc_cnt);
          check("tick_wrap", {7'b0, tk_w}, {7'b0, mon_e.tk}, cyc_cnt);
          check("tick_sat", {7'b0, tk_s}, {7'b0, mon_e.tk}, cyc_cnt);
          check("tc_wrap", {7'b0, tc_w}, {7'b0, mon_e.tcw}, cyc_cnt);
          check("tc_sat", {7'b0, tc_s}, {7'b0, mon_e.tcs}, cyc_cnt);
          check("load_err_wrap", {7'b0, le_w}, {7'b0, mon_e.le}, cyc_cnt);
          check("load_err_sat", {7'b0, le_s}, {7'b0, mon_e.le}, cyc_cnt);
        end
        if (mon_e.fast_chk) begin
          check("count_div1", cnt_f, mon_e.cf, cyc_cnt);
          check("tick_div1", {7'b0, tk_f}, {7'b0, mon_e.tkf}, cyc_cnt);
          check("tc_div1", {7'b0, tc_f}, {7'b0, mon_e.tcf}, cyc_cnt);
          check("load_err_div1", {7'b0, le_f}, 8'h00, cyc_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1;

    // reset: cleared state, tick suppressed, tc from reset count; reset beats load
    step_main(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    step_main(1, 1, 0, 1, 8'h55, 8'h00, 8'h00, 0, 1, 1, 0);

    // count up: tick every 4th cycle, 09 -> 10 on the 10th tick
    for (int j = 0; j <= 40; j++) begin
      step_main(0, 1, 1, 0, 8'h00, bcd2(j / 4), bcd2(j / 4), (j % 4 == 3), 0, 0, 0);
    end

    // up terminal: wrap to 00 versus hold at 99
    step_main(0, 1, 1, 1, 8'h99, 8'h10, 8'h10, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step_main(0, 1, 1, 0, 8'h00, 8'h99, 8'h99, (j == 3), 1, 1, 0);
    end
    step_main(0, 0, 1, 0, 8'h00, 8'h00, 8'h99, 0, 0, 1, 0);

    // down terminal: wrap to 99 versus hold at 00
    step_main(0, 0, 0, 1, 8'h00, 8'h00, 8'h99, 0, 1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step_main(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, (j == 3), 1, 1, 0);
    end
    step_main(0, 0, 0, 0, 8'h00, 8'h99, 8'h00, 0, 0, 1, 0);

    // 10 - 1 borrows across the decade
    step_main(0, 0, 0, 1, 8'h10, 8'h99, 8'h00, 0, 0, 1, 0);
    for (int j = 0; j < 4; j++) begin
      step_main(0, 1, 0, 0, 8'h00, 8'h10, 8'h10, (j == 3), 0, 0, 0);
    end
    step_main(0, 0, 0, 0, 8'h00, 8'h09, 8'h09, 0, 0, 0, 0);

    // direction flip just before the tick: one up step, none lost or added
    for (int j = 0; j < 3; j++) begin
      step_main(0, 1, 0, 0, 8'h00, 8'h09, 8'h09, 0, 0, 0, 0);
    end
    step_main(0, 1, 1, 0, 8'h00, 8'h09, 8'h09, 1, 0, 0, 0);
    step_main(0, 0, 1, 0, 8'h00, 8'h10, 8'h10, 0, 0, 0, 0);

    // load 37 clears the prescaler: first tick four en-cycles later
    step_main(0, 1, 1, 1, 8'h37, 8'h10, 8'h10, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step_main(0, 1, 1, 0, 8'h00, 8'h37, 8'h37, (j == 3), 0, 0, 0);
    end
    step_main(0, 0, 1, 0, 8'h00, 8'h38, 8'h38, 0, 0, 0, 0);

    // invalid load 3A mid-period: count and prescaler held, one-cycle load_err
    step_main(0, 1, 1, 0, 8'h00, 8'h38, 8'h38, 0, 0, 0, 0);
    step_main(0, 1, 1, 0, 8'h00, 8'h38, 8'h38, 0, 0, 0, 0);
    step_main(0, 1, 1, 1, 8'h3A, 8'h38, 8'h38, 0, 0, 0, 0);
    step_main(0, 1, 1, 0, 8'h00, 8'h38, 8'h38, 0, 0, 0, 1);
    step_main(0, 1, 1, 0, 8'h00, 8'h38, 8'h38, 1, 0, 0, 0);
    step_main(0, 0, 1, 0, 8'h00, 8'h39, 8'h39, 0, 0, 0, 0);

    // load on the prescaler's last count suppresses that step
    for (int j = 0; j < 3; j++) begin
      step_main(0, 1, 1, 0, 8'h00, 8'h39, 8'h39, 0, 0, 0, 0);
    end
    step_main(0, 1, 1, 1, 8'h42, 8'h39, 8'h39, 0, 0, 0, 0);
    step_main(0, 0, 1, 0, 8'h00, 8'h42, 8'h42, 0, 0, 0, 0);

    // en low for 10 cycles mid-period freezes everything
    step_main(0, 1, 1, 0, 8'h00, 8'h42, 8'h42, 0, 0, 0, 0);
    step_main(0, 1, 1, 0, 8'h00, 8'h42, 8'h42, 0, 0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      step_main(0, 0, 1, 0, 8'h00, 8'h42, 8'h42, 0, 0, 0, 0);
    end
    step_main(0, 1, 1, 0, 8'h00, 8'h42, 8'h42, 0, 0, 0, 0);
    step_main(0, 1, 1, 0, 8'h00, 8'h42, 8'h42, 1, 0, 0, 0);
    step_main(0, 0, 1, 0, 8'h00, 8'h43, 8'h43, 0, 0, 0, 0);

    // DIV=1: a step on every enabled cycle, wrapping past 99
    step_free(1, 1, 1, 0, 8'h00);
    for (int j = 0; j < 12; j++) begin
      step_fast(0, 1, 1, 0, 8'h00, bcd2(j), 1, 0);
    end
    step_fast(0, 1, 1, 1, 8'h95, 8'h12, 0, 0);
    for (int j = 0; j < 5; j++) begin
      step_fast(0, 1, 1, 0, 8'h00, bcd2(95 + j), 1, (j == 4));
    end
    step_fast(0, 1, 1, 0, 8'h00, 8'h00, 1, 0);
    step_fast(0, 0, 1, 0, 8'h00, 8'h01, 0, 0);

    drive(0, 0, 1, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
